// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage controller: PC sequencing, load-use stall, branch flush, drain/done
module fetch_ctrl #(
  parameter int IMEM_BYTES   = 20,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs2,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic [31:0] pc_shadow,
  output logic [2:0]  state,
  output logic        done,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3
  } state_t;

  localparam logic [31:0] LAST_ADDR  = 32'(IMEM_BYTES - 4);
  localparam logic [15:0] DRAIN_INIT = 16'(DRAIN_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] drain_q, drain_d;
  logic [15:0] stall_q, flush_q;
  logic        stalled_q, stalled_d;
  logic        stall_evt, flush_evt;

  logic        hazard, last, oob;
  logic        pc_write_c, pc_sel_c, ifid_write_c, ifid_flush_c, idex_bubble_c, done_c;

  // A stall lets the load advance, so a hazard still visible right after a stall is the same one.
  assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                  ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2))) && !stalled_q;
  assign last   = (pc_q == LAST_ADDR);
  assign oob    = (pc_q > LAST_ADDR);

  always_comb begin
    pc_write_c    = 1'b0;
    pc_sel_c      = 1'b0;
    ifid_write_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    done_c        = 1'b0;
    state_d       = state_q;
    pc_d          = pc_q;
    drain_d       = drain_q;
    stalled_d     = 1'b0;
    stall_evt     = 1'b0;
    flush_evt     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end

      S_RUN: begin
        if (br_taken) begin
          pc_write_c    = 1'b1;
          pc_sel_c      = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          pc_d          = br_target;
          flush_evt     = 1'b1;
        end else if (hazard) begin
          idex_bubble_c = 1'b1;
          stall_evt     = 1'b1;
          stalled_d     = 1'b1;
        end else if (oob) begin
          // Nothing valid to fetch, so this cycle already counts as one bubble.
          ifid_flush_c = 1'b1;
          state_d      = S_DRAIN;
          drain_d      = DRAIN_INIT - 16'd1;
        end else if (last) begin
          ifid_write_c = 1'b1;
          state_d      = S_DRAIN;
          drain_d      = DRAIN_INIT;
        end else begin
          pc_write_c   = 1'b1;
          ifid_write_c = 1'b1;
          pc_d         = pc_q + 32'd4;
        end
      end

      S_DRAIN: begin
        if (br_taken) begin
          pc_write_c    = 1'b1;
          pc_sel_c      = 1'b1;
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          pc_d          = br_target;
          flush_evt     = 1'b1;
          state_d       = S_RUN;
          drain_d       = 16'd0;
        end else begin
          ifid_flush_c = 1'b1;
          drain_d      = (drain_q == 16'd0) ? 16'd0 : drain_q - 16'd1;
          // Leave in the same edge that the counter lands on zero.
          if (drain_q <= 16'd1) state_d = S_DONE;
        end
      end

      S_DONE: begin
        done_c = 1'b1;
        if (start) begin
          state_d = S_RUN;
          pc_d    = 32'd0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= 32'd0;
      drain_q   <= 16'd0;
      stall_q   <= 16'd0;
      flush_q   <= 16'd0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      drain_q   <= drain_d;
      stalled_q <= stalled_d;
      if (stall_evt && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
      if (flush_evt && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
    end
  end

  // Reset is synchronous, so mask the combinational enables while it is asserted.
  assign pc_write    = pc_write_c    & ~rst_n;
  assign pc_sel      = pc_sel_c      & ~rst_n;
  assign ifid_write  = ifid_write_c  & ~rst_n;
  assign ifid_flush  = ifid_flush_c  & ~rst_n;
  assign idex_bubble = idex_bubble_c & ~rst_n;
  assign done        = done_c        & ~rst_n;

  assign pc_shadow = pc_q;
  assign state     = state_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl with a behavioural reference model
module tb_fetch_ctrl;
  localparam int IMEM  = 20;
  localparam int DRAIN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, ex_mem_read = 1'b0, id_uses_rs2 = 1'b0, br_taken = 1'b0;
  logic [4:0]  ex_rd = '0, id_rs1 = '0, id_rs2 = '0;
  logic [31:0] br_target = '0;
  logic        pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble, done;
  logic [31:0] pc_shadow;
  logic [2:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_ctrl #(.IMEM_BYTES(IMEM), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .br_taken(br_taken),
    .br_target(br_target), .pc_write(pc_write), .pc_sel(pc_sel), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pc_shadow(pc_shadow), .state(state),
    .done(done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0=idle 1=run 2=drain 3=done; bubbles_left counts remaining drain bubbles.
  int          m_phase = 0, n_phase;
  logic [31:0] m_pc = 0, n_pc;
  int          m_stalls = 0, n_stalls, m_flushes = 0, n_flushes;
  int          m_bubbles_left = 0, n_bubbles_left;
  bit          m_just_stalled = 0, n_just_stalled;
  bit          e_pw, e_ps, e_iw, e_if, e_ib, e_done;

  task automatic model_eval();
    bit hz;
    hz = ex_mem_read && ex_rd != 0 &&
         (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2)) && !m_just_stalled;
    {e_pw, e_ps, e_iw, e_if, e_ib, e_done} = '0;
    n_phase = m_phase; n_pc = m_pc; n_stalls = m_stalls; n_flushes = m_flushes;
    n_bubbles_left = m_bubbles_left; n_just_stalled = 0;
    if (rst_n) begin
      n_phase = 0; n_pc = 0; n_stalls = 0; n_flushes = 0; n_bubbles_left = 0;
    end else if (m_phase == 0) begin
      if (start) n_phase = 1;
    end else if (m_phase == 3) begin
      e_done = 1;
      if (start) begin n_phase = 1; n_pc = 0; end
    end else if (br_taken) begin
      {e_pw, e_ps, e_if, e_ib} = 4'hF;
      n_pc = br_target;
      n_flushes = (m_flushes < 65535) ? m_flushes + 1 : 65535;
      n_phase = 1; n_bubbles_left = 0;
    end else if (m_phase == 2) begin
      e_if = 1;
      n_bubbles_left = (m_bubbles_left > 0) ? m_bubbles_left - 1 : 0;
      if (n_bubbles_left == 0) n_phase = 3;
    end else if (hz) begin
      e_ib = 1;
      n_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
      n_just_stalled = 1;
    end else if (m_pc > IMEM - 4) begin
      e_if = 1; n_phase = 2; n_bubbles_left = DRAIN - 1;
    end else if (m_pc == IMEM - 4) begin
      e_iw = 1; n_phase = 2; n_bubbles_left = DRAIN;
    end else begin
      e_pw = 1; e_iw = 1; n_pc = m_pc + 32'd4;
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    m_phase = n_phase; m_pc = n_pc; m_stalls = n_stalls; m_flushes = n_flushes;
    m_bubbles_left = n_bubbles_left; m_just_stalled = n_just_stalled;
    @(negedge clk);
  endtask

  task automatic clr_in();
    start = 0; ex_mem_read = 0; id_uses_rs2 = 0; br_taken = 0;
    ex_rd = 0; id_rs1 = 0; id_rs2 = 0; br_target = 0;
  endtask

  task automatic test_reset();
    rst_n = 1; start = 1; br_taken = 1; br_target = 32'h40;
    tick(); tick();
    #1;
    n_checks++;
    if ({state, pc_shadow, stall_cnt, flush_cnt} !== {3'd0, 32'd0, 16'd0, 16'd0})
      $display("FAIL reset_regs state=%0d pc=%0h stall=%0d flush=%0d want 0", state, pc_shadow, stall_cnt, flush_cnt);
    else n_pass++;
    n_checks++;
    if ({pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble, done} !== 6'b0)
      $display("FAIL reset_outs got=%b want 000000", {pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble, done});
    else n_pass++;
    rst_n = 0; clr_in(); #1;
    n_checks++;
    if ({pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble, done} !== 6'b0)
      $display("FAIL post_reset_outs got=%b want 000000", {pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble, done});
    else n_pass++;
  endtask

  task automatic test_full_run();
    start = 1; tick(); start = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (pc_shadow !== 32'(4 * k) || state !== 3'd1 || pc_write !== (k < 4) || ifid_write !== 1'b1)
        $display("FAIL run_step%0d pc=%0d state=%0d pw=%b iw=%b want pc=%0d state=1 pw=%b iw=1",
                 k, pc_shadow, state, pc_write, ifid_write, 4 * k, k < 4);
      else n_pass++;
      tick();
    end
    for (int k = 0; k < DRAIN; k++) begin
      #1;
      n_checks++;
      if (state !== 3'd2 || ifid_flush !== 1'b1 || done !== 1'b0 || pc_write !== 1'b0)
        $display("FAIL drain_cyc%0d state=%0d if=%b done=%b pw=%b want 2/1/0/0", k, state, ifid_flush, done, pc_write);
      else n_pass++;
      tick();
    end
    #1;
    n_checks++;
    if (done !== 1'b1 || state !== 3'd3 || stall_cnt !== 16'd0)
      $display("FAIL run_done done=%b state=%0d stall=%0d want 1/3/0", done, state, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_hazard();
    start = 1; tick(); start = 0; tick(); tick();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; #1;
    n_checks++;
    if (pc_shadow !== 32'd8 || pc_write !== 1'b0 || idex_bubble !== 1'b1 || ifid_write !== 1'b0)
      $display("FAIL hazard_stall pc=%0d pw=%b ib=%b iw=%b want 8/0/1/0", pc_shadow, pc_write, idex_bubble, ifid_write);
    else n_pass++;
    tick(); clr_in(); #1;
    n_checks++;
    if (pc_shadow !== 32'd8 || stall_cnt !== 16'd1)
      $display("FAIL hazard_after pc=%0d stall=%0d want 8/1", pc_shadow, stall_cnt);
    else n_pass++;
    tick();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 3; id_rs2 = 5; id_uses_rs2 = 0; #1;
    n_checks++;
    if (pc_write !== 1'b1 || idex_bubble !== 1'b0)
      $display("FAIL rs2_unused pw=%b ib=%b want 1/0", pc_write, idex_bubble);
    else n_pass++;
    tick();
    ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 1; #1;
    n_checks++;
    if (idex_bubble !== 1'b0 || ifid_write !== 1'b1 || pc_shadow !== 32'd16)
      $display("FAIL rd_zero ib=%b iw=%b pc=%0d want 0/1/16", idex_bubble, ifid_write, pc_shadow);
    else n_pass++;
    tick(); clr_in();
    repeat (DRAIN) tick();
    #1;
    n_checks++;
    if (done !== 1'b1 || stall_cnt !== 16'd1)
      $display("FAIL hazard_done done=%b stall=%0d want 1/1", done, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_branch_hazard();
    start = 1; tick(); start = 0; tick();
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; br_taken = 1; br_target = 4; #1;
    n_checks++;
    if ({pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble} !== 5'b11011)
      $display("FAIL br_hazard_outs got=%b want 11011", {pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble});
    else n_pass++;
    tick(); clr_in(); #1;
    n_checks++;
    if (pc_shadow !== 32'd4 || flush_cnt !== 16'd1 || stall_cnt !== 16'd1)
      $display("FAIL br_hazard_after pc=%0d flush=%0d stall=%0d want 4/1/1", pc_shadow, flush_cnt, stall_cnt);
    else n_pass++;
  endtask

  task automatic test_drain_branch();
    int cyc;
    cyc = 0;
    #1;
    while (state !== 3'd2 && cyc < 20) begin tick(); cyc++; #1; end
    tick();
    br_taken = 1; br_target = 0; #1;
    n_checks++;
    if (state !== 3'd2 || pc_sel !== 1'b1 || ifid_flush !== 1'b1)
      $display("FAIL drain_br_outs state=%0d ps=%b if=%b want 2/1/1", state, pc_sel, ifid_flush);
    else n_pass++;
    tick(); clr_in(); #1;
    n_checks++;
    if (state !== 3'd1 || pc_shadow !== 32'd0 || done !== 1'b0 || flush_cnt !== 16'd2)
      $display("FAIL drain_br_after state=%0d pc=%0d done=%b flush=%0d want 1/0/0/2", state, pc_shadow, done, flush_cnt);
    else n_pass++;
    cyc = 0;
    while (done !== 1'b1 && cyc < 50) begin tick(); cyc++; #1; end
    n_checks++;
    if (cyc !== 9) $display("FAIL rerun_len cycles=%0d want 9", cyc);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    start = 1; tick(); start = 0;
    cyc = 0;
    #1;
    while (state !== 3'd2 && cyc < 20) begin tick(); cyc++; #1; end
    tick();
    rst_n = 1; br_taken = 1; #1;
    n_checks++;
    if ({pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble, done} !== 6'b0)
      $display("FAIL mid_reset_outs got=%b want 000000", {pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble, done});
    else n_pass++;
    tick(); rst_n = 0; clr_in(); #1;
    n_checks++;
    if ({state, pc_shadow, stall_cnt, flush_cnt} !== {3'd0, 32'd0, 16'd0, 16'd0})
      $display("FAIL mid_reset_regs state=%0d pc=%0d stall=%0d flush=%0d want 0", state, pc_shadow, stall_cnt, flush_cnt);
    else n_pass++;
  endtask

  task automatic test_oob();
    int cyc;
    start = 1; tick(); start = 0;
    br_taken = 1; br_target = 24; tick(); clr_in(); #1;
    n_checks++;
    if (state !== 3'd1 || pc_shadow !== 32'd24 || {pc_write, ifid_write, ifid_flush} !== 3'b001)
      $display("FAIL oob_cycle state=%0d pc=%0d pw/iw/if=%b want 1/24/001", state, pc_shadow, {pc_write, ifid_write, ifid_flush});
    else n_pass++;
    tick();
    cyc = 0;
    #1;
    while (state === 3'd2 && cyc < 20) begin tick(); cyc++; #1; end
    n_checks++;
    if (cyc !== DRAIN - 1 || done !== 1'b1 || pc_shadow !== 32'd24)
      $display("FAIL oob_drain cycles=%0d done=%b pc=%0d want %0d/1/24", cyc, done, pc_shadow, DRAIN - 1);
    else n_pass++;
  endtask

  task automatic test_saturate();
    start = 1; tick(); start = 0;
    br_taken = 1; br_target = 0;
    repeat (65540) tick();
    clr_in(); #1;
    n_checks++;
    if (flush_cnt !== 16'hFFFF) $display("FAIL flush_saturate got=%0h want ffff", flush_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    rst_n = 1; tick(); rst_n = 0;
    for (int i = 0; i < 4000; i++) begin
      rst_n       = ($urandom_range(0, 299) == 0);
      start       = ($urandom_range(0, 3) == 0);
      br_taken    = ($urandom_range(0, 9) == 0);
      br_target   = 32'($urandom_range(0, 7) * 4);
      ex_mem_read = ($urandom_range(0, 2) == 0);
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_uses_rs2 = 1'($urandom_range(0, 1));
      #1;
      model_eval();
      n_checks++;
      if ({pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble, done} !== {e_pw, e_ps, e_iw, e_if, e_ib, e_done} ||
          state !== 3'(m_phase) || pc_shadow !== m_pc ||
          stall_cnt !== 16'(m_stalls) || flush_cnt !== 16'(m_flushes))
        $display("FAIL random_cyc%0d outs=%b want %b state=%0d/%0d pc=%0h/%0h stall=%0d/%0d flush=%0d/%0d",
                 i, {pc_write, pc_sel, ifid_write, ifid_flush, idex_bubble, done},
                 {e_pw, e_ps, e_iw, e_if, e_ib, e_done}, state, m_phase, pc_shadow, m_pc,
                 stall_cnt, m_stalls, flush_cnt, m_flushes);
      else n_pass++;
      tick();
    end
    rst_n = 0; clr_in();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_run();
    test_hazard();
    test_branch_hazard();
    test_drain_branch();
    test_reset_mid();
    test_oob();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
